// File: rtl/shift_unit_seq.sv
// shift_unit_seq
//   Multicycle shifter beside the ALU. A start in IDLE captures the operand,
//   the shift op and the shift amount. The block then shifts the result
//   register one bit per cycle until the count is used up. It pulses done
//   for one cycle, and the result holds until the next accepted start.
//
//   Optional feature macro: SHIFT_STEP4_EN
//     When defined, a SHIFT cycle with count >= 4 moves 4 bits at once.
//     When undefined, the block shifts strictly 1 bit per cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   ShiftOp      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   ShiftAmt_in  shift count
//   Data_in      operand
//   busy         high in SHIFT and DONE
//   done         one-cycle pulse, Shift_out valid
//   Shift_out    result register
module shift_unit_seq #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ShiftOp,
  input  logic [AMT_W-1:0]  ShiftAmt_in,
  input  logic [DATA_W-1:0] Data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Shift_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [AMT_W-1:0] ZERO = '0;
  localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);

  state_t            state, state_nxt;
  logic [1:0]        op;
  logic [1:0]        op_nxt;
  logic [AMT_W-1:0]  count, count_nxt;
  logic [DATA_W-1:0] data_nxt;

  function automatic logic [DATA_W-1:0] step1(input logic [1:0] o,
                                              input logic [DATA_W-1:0] x);
    case (o)
      2'b00:   step1 = {x[DATA_W-2:0], 1'b0};
      2'b01:   step1 = {1'b0, x[DATA_W-1:1]};
      2'b10:   step1 = {x[DATA_W-1], x[DATA_W-1:1]};
      default: step1 = {x[0], x[DATA_W-1:1]};
    endcase
  endfunction

`ifdef SHIFT_STEP4_EN
  localparam logic [AMT_W-1:0] FOUR = AMT_W'(4);

  function automatic logic [DATA_W-1:0] step4(input logic [1:0] o,
                                              input logic [DATA_W-1:0] x);
    case (o)
      2'b00:   step4 = {x[DATA_W-5:0], 4'b0000};
      2'b01:   step4 = {4'b0000, x[DATA_W-1:4]};
      2'b10:   step4 = {{4{x[DATA_W-1]}}, x[DATA_W-1:4]};
      default: step4 = {x[3:0], x[DATA_W-1:4]};
    endcase
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    data_nxt  = Shift_out;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          data_nxt  = Data_in;
          count_nxt = ShiftAmt_in;
          op_nxt    = ShiftOp;
        end
      end
      SHIFT: begin
        if (count == ZERO) begin
          state_nxt = DONE;
`ifdef SHIFT_STEP4_EN
        end else if (count >= FOUR) begin
          data_nxt  = step4(op, Shift_out);
          count_nxt = count - FOUR;
          if (count == FOUR) state_nxt = DONE;
`endif
        end else begin
          data_nxt  = step1(op, Shift_out);
          count_nxt = count - ONE;
          if (count == ONE) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;  // unused encoding returns to IDLE
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      op        <= '0;
      Shift_out <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      op        <= op_nxt;
      Shift_out <= data_nxt;
    end
  end

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    ShiftOp;
  logic [AW-1:0] ShiftAmt_in;
  logic [DW-1:0] Data_in;
  logic          busy, done;
  logic [DW-1:0] Shift_out;

  int checks = 0;
  int failures = 0;

  shift_unit_seq #(.DATA_W(DW), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .ShiftOp(ShiftOp),
    .ShiftAmt_in(ShiftAmt_in), .Data_in(Data_in),
    .busy(busy), .done(done), .Shift_out(Shift_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result: the whole shift applied at once with plain operators.
  function automatic logic [DW-1:0] ref_shift(input logic [1:0] op, input int amt,
                                              input logic [DW-1:0] x);
    logic [DW-1:0] r;
    case (op)
      2'd0: r = x << amt;
      2'd1: r = x >> amt;
      2'd2: r = $signed(x) >>> amt;
      default: r = (amt == 0) ? x : ((x >> amt) | (x << (DW - amt)));
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input int amt);
    int l;
`ifdef SHIFT_STEP4_EN
    l = amt / 4 + amt % 4;
`else
    l = amt;
`endif
    return (l < 1) ? 1 : l;
  endfunction

  // Start at edge k. Inputs are scrambled after k. When inj > 0, start is
  // pulsed again with new data, sampled at edge k+inj.
  task automatic run_op(input string tag, input logic [1:0] op, input int amt,
                        input logic [DW-1:0] data, input int inj);
    logic [DW-1:0] exp;
    int lat, cyc;
    bit seen;
    exp = ref_shift(op, amt, data);
    lat = ref_lat(amt);
    ShiftOp = op; ShiftAmt_in = AW'(amt); Data_in = data; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ShiftOp = 2'($urandom); ShiftAmt_in = AW'($urandom); Data_in = $urandom;
    cyc = 0; seen = 0;
    if (inj == 1) begin start = 1'b1; Data_in = $urandom; end
    while (!seen && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (inj > 0 && cyc == inj - 1) begin start = 1'b1; Data_in = $urandom; end
      if (inj > 0 && cyc == inj) start = 1'b0;
      if (done) seen = 1;
      else check({tag, " busy"}, {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, Shift_out, exp);
    @(posedge clk); #1;
    check({tag, " done_width"}, {31'd0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " hold"}, Shift_out, exp);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ShiftOp = '0; ShiftAmt_in = '0; Data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst out", Shift_out, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_op("sll4",    2'd0, 4,  32'h0000_0001, 0);
    run_op("sra31",   2'd2, 31, 32'h8000_0000, 0);
    run_op("srl16",   2'd1, 16, 32'h8000_0000, 0);
    run_op("ror4",    2'd3, 4,  32'h0000_000F, 0);
    run_op("amt0sll", 2'd0, 0,  32'hDEAD_BEEF, 0);
    run_op("amt0ror", 2'd3, 0,  32'hDEAD_BEEF, 0);
    run_op("restart", 2'd0, 8,  32'h1234_5678, 2);

    // Reset mid-shift at k+3 of an amt=10 shift.
    ShiftOp = 2'd0; ShiftAmt_in = AW'(10); Data_in = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst out", Shift_out, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    run_op("postrst", 2'd1, 10, 32'hF000_0000, 0);

    for (int i = 0; i < 24; i++) begin
      run_op("rand", 2'($urandom), int'($urandom_range(0, 31)), $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
